// File: rtl/dac_spi_serializer_if.sv
// dac_spi_serializer_if
//   Bundles the sample-tick / ROM-data input side and the SPI + status output
//   side of the DAC serializer so both ends connect through a single port.
// Signals
//   sample_en  1-cycle sample tick (same strobe as the ROM enable)
//   data_in    ROM data word, valid the cycle after sample_en
//   sclk       SPI clock to the DAC (mode 0)
//   cs_n       SPI chip select, active-low
//   mosi       SPI data, MSB first
//   busy       high from an accepted tick until the frame and CS hold finish
//   done       1-cycle pulse when a frame completes
//   overrun    1-cycle pulse when a tick arrives while busy
// Modports
//   master     upstream sample-rate logic: drives the tick and data, reads status
//   slave      the serializer itself
interface dac_spi_serializer_if #(
  parameter int IN_WIDTH = 32
);
  logic                sample_en;
  logic [IN_WIDTH-1:0] data_in;
  logic                sclk;
  logic                cs_n;
  logic                mosi;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output sample_en, data_in,
    input  sclk, cs_n, mosi, busy, done, overrun
  );

  modport slave (
    input  sample_en, data_in,
    output sclk, cs_n, mosi, busy, done, overrun
  );
endinterface

// File: rtl/dac_spi_serializer.sv
// dac_spi_serializer
//   Captures the sine-table ROM word one cycle after each sample tick (to
//   cover the ROM's synchronous read latency), then shifts its low FRAME_BITS
//   bits out MSB-first to an SPI DAC in mode 0 (CPOL=0, CPHA=0). Reports
//   busy, frame-done and overrun status back to the sample-rate logic.
// Parameters
//   IN_WIDTH    width of the ROM data word
//   FRAME_BITS  bits per SPI frame, taken from data_in[FRAME_BITS-1:0]
//   SCLK_DIV    clk cycles per sclk half-period (>= 1)
//   CS_HIGH     clk cycles cs_n stays high after a frame before going idle (>= 1)
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high; aborts any frame in flight
//   bus         dac_spi_serializer_if slave modport (tick, data, SPI, status)
module dac_spi_serializer #(
  parameter int IN_WIDTH   = 32,
  parameter int FRAME_BITS = 16,
  parameter int SCLK_DIV   = 4,
  parameter int CS_HIGH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dac_spi_serializer_if.slave  bus
);

  localparam int BCW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int DW  = $clog2(SCLK_DIV + 1);
  localparam int HW  = $clog2(CS_HIGH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shReg;
  logic [BCW-1:0]        r_bitCnt;
  logic [DW-1:0]         r_divCnt;
  logic [HW-1:0]         r_holdCnt;
  logic                  r_sclk;
  logic                  r_csN;
  logic                  r_mosi;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;

  // Shift register advanced by one bit; its MSB is the next bit to present.
  logic [FRAME_BITS-1:0] w_nextShReg;
  assign w_nextShReg = r_shReg << 1;

  // Upper ROM bits beyond the frame are intentionally discarded.
  generate
    if (IN_WIDTH > FRAME_BITS) begin : g_unusedHigh
      logic w_unused;
      assign w_unused = ^bus.data_in[IN_WIDTH-1:FRAME_BITS];
    end
  endgenerate

  // Single FSM: IDLE -> WAIT (ROM latency) -> SHIFT -> HOLD -> IDLE.
  // All SPI and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shReg   <= '0;
      r_bitCnt  <= '0;
      r_divCnt  <= '0;
      r_holdCnt <= '0;
      r_sclk    <= 1'b0;
      r_csN     <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Any tick outside IDLE is dropped and flagged for exactly one cycle.
      r_overrun <= bus.sample_en && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.sample_en) begin
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ROM word is valid now; latch it once and present the MSB.
          r_shReg  <= bus.data_in[FRAME_BITS-1:0];
          r_mosi   <= bus.data_in[FRAME_BITS-1];
          r_csN    <= 1'b0;
          r_sclk   <= 1'b0;
          r_bitCnt <= BCW'(FRAME_BITS - 1);
          r_divCnt <= '0;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_divCnt == DW'(SCLK_DIV - 1)) begin
            r_divCnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // Falling sclk: move to the next bit, or close the frame after bit 0.
              r_sclk <= 1'b0;
              if (r_bitCnt == '0) begin
                r_csN     <= 1'b1;
                r_holdCnt <= '0;
                r_state   <= S_HOLD;
              end else begin
                r_bitCnt <= r_bitCnt - BCW'(1);
                r_shReg  <= w_nextShReg;
                r_mosi   <= w_nextShReg[FRAME_BITS-1];
              end
            end
          end else begin
            r_divCnt <= r_divCnt + DW'(1);
          end
        end
        S_HOLD: begin
          if (r_holdCnt == HW'(CS_HIGH - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_holdCnt <= r_holdCnt + HW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sclk    = r_sclk;
  assign bus.cs_n    = r_csN;
  assign bus.mosi    = r_mosi;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// tb_dac_spi_serializer
//   Directed bench for dac_spi_serializer with default parameters. Stimulus
//   pushes expected frame words and event cycles into queues; an independent
//   monitor decodes the SPI lines and pops/compares as events appear.
module tb_dac_spi_serializer;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] expWordQ[$];
  int          expFallQ[$];
  int          expRiseQ[$];
  int          expDoneQ[$];
  int          expOvQ[$];

  dac_spi_serializer_if #(.IN_WIDTH(32)) bus ();

  dac_spi_serializer #(
    .IN_WIDTH  (32),
    .FRAME_BITS(16),
    .SCLK_DIV  (4),
    .CS_HIGH   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz clock and a cycle index that advances on every rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cycle);
    end
  endtask

  function automatic int popInt(inout int q[$]);
    if (q.size() > 0) return q.pop_front();
    return -1;
  endfunction

  // Hand-built stand-in for the sine ROM: distinct upper bits that must be dropped.
  function automatic logic [31:0] romWord(input int a);
    logic [15:0] v;
    v = 16'(a * 1031) ^ 16'h5A5A;
    return {8'hC0, 8'(a), v};
  endfunction

  // Issue one tick in the current cycle T, present data at T+1, then scramble it.
  task automatic applyStimulus(input logic [31:0] word);
    int t;
    t = cycle;
    expWordQ.push_back(word[15:0]);
    expFallQ.push_back(t + 2);
    expRiseQ.push_back(t + 130);
    expDoneQ.push_back(t + 132);
    bus.sample_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    bus.data_in   = word;
    @(negedge clk);
    checkOutput("busy_after_tick", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    bus.data_in = ~word;
  endtask

  task automatic waitUntil(input int c);
    while (cycle < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: decode SPI frames and status pulses, compare against the queues.
  logic        prevSclk = 1'b0;
  logic        prevCs = 1'b1;
  logic        prevMosi = 1'b0;
  logic        started = 1'b0;
  logic        sawReset = 1'b0;
  int          bitCount = 0;
  logic [15:0] rxWord = '0;

  always @(negedge clk) begin
    if (started && !rst) begin
      if (prevCs && !bus.cs_n) begin
        checkOutput("cs_fall_cycle", cycle, popInt(expFallQ));
        bitCount = 0;
        rxWord   = '0;
        sawReset = 1'b0;
      end
      if (!bus.cs_n && !prevSclk && bus.sclk) begin
        rxWord   = {rxWord[14:0], bus.mosi};
        bitCount = bitCount + 1;
      end
      if (prevSclk && bus.sclk)
        checkOutput("mosi_stable_high", {31'd0, bus.mosi}, {31'd0, prevMosi});
      if (!prevCs && bus.cs_n) begin
        if (sawReset) begin
          sawReset = 1'b0;
        end else begin
          checkOutput("frame_bits", bitCount, 32'd16);
          checkOutput("frame_word", {16'd0, rxWord}, (expWordQ.size() > 0) ? {16'd0, expWordQ.pop_front()} : 32'hFFFF_FFFF);
          checkOutput("cs_rise_cycle", cycle, popInt(expRiseQ));
        end
      end
      if (bus.done) begin
        checkOutput("done_cycle", cycle, popInt(expDoneQ));
        checkOutput("busy_at_done", {31'd0, bus.busy}, 32'd0);
      end
      if (bus.overrun)
        checkOutput("overrun_cycle", cycle, popInt(expOvQ));
    end
    if (rst) sawReset = 1'b1;
    prevSclk = bus.sclk;
    prevCs   = bus.cs_n;
    prevMosi = bus.mosi;
  end

  initial begin
    int t0;
    int t1;
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    started = 1'b1;

    // Quiet period after reset: all outputs at their idle values.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", {26'd0, bus.cs_n, bus.sclk, bus.mosi, bus.busy, bus.done, bus.overrun}, 32'h20);
    end
    @(posedge clk); #1;

    // Frame A5C3, overrun tick mid-frame, then a tick exactly on the done cycle.
    t0 = cycle;
    applyStimulus(32'h1234_A5C3);
    waitUntil(t0 + 60);
    expOvQ.push_back(t0 + 61);
    bus.sample_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    waitUntil(t0 + 132);
    t1 = cycle;
    applyStimulus(32'hFFFF_3C5A);
    waitUntil(t1 + 160);

    // ROM sweep: 64 ticks, 1000 cycles apart.
    for (int a = 0; a < 64; a++) begin
      t0 = cycle;
      applyStimulus(romWord(a));
      waitUntil(t0 + 1000);
    end

    // Mid-frame reset aborts the frame with no done pulse.
    t0 = cycle;
    applyStimulus(32'h0000_5AA5);
    waitUntil(t0 + 70);
    rst = 1'b1;
    expWordQ.delete();
    expRiseQ.delete();
    expDoneQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_abort", {28'd0, bus.cs_n, bus.sclk, bus.busy, bus.done}, 32'h8);
    @(posedge clk); #1;
    waitUntil(t0 + 200);
    t1 = cycle;
    applyStimulus(32'hABCD_0F1E);
    waitUntil(t1 + 160);

    checkOutput("pending_words", expWordQ.size(), 32'd0);
    checkOutput("pending_falls", expFallQ.size(), 32'd0);
    checkOutput("pending_rises", expRiseQ.size(), 32'd0);
    checkOutput("pending_dones", expDoneQ.size(), 32'd0);
    checkOutput("pending_overruns", expOvQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
